// File: rtl/range_match_stream.sv
// Single-stage streaming classifier: tags each accepted word with a mask of
// the programmable inclusive ranges it falls in and counts delivered hits.
module range_match_stream #(
    parameter int WIDTH      = 3,
    parameter int NUM_RANGES = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_LO     = 4,
    parameter int DEF_HI     = 6,
    localparam int IDX_W     = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [WIDTH-1:0]      cfg_lo,
    input  logic [WIDTH-1:0]      cfg_hi,
    input  logic                  cfg_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_hit,
    output logic [NUM_RANGES-1:0] out_mask,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]      lo_q [NUM_RANGES];
    logic [WIDTH-1:0]      hi_q [NUM_RANGES];
    logic [NUM_RANGES-1:0] en_q;
    logic [NUM_RANGES-1:0] match;
    logic                  accept;
    logic                  deliver;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    // NOTE: the range table is a handful of flops with defined reset contents,
    // so it is reset like any other register rather than treated as a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RANGES; i++) begin
                lo_q[i] <= (i == 0) ? WIDTH'(DEF_LO) : '0;
                hi_q[i] <= (i == 0) ? WIDTH'(DEF_HI) : '0;
            end
            en_q <= NUM_RANGES'(1);
        end else if (cfg_we) begin
            // Indices beyond the table match no entry and are dropped.
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    lo_q[i] <= cfg_lo;
                    hi_q[i] <= cfg_hi;
                    en_q[i] <= cfg_en;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_RANGES; i++) begin
            match[i] = en_q[i] && (lo_q[i] <= in_data) && (in_data <= hi_q[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which also makes a same-edge cfg write invisible
    // to the word being classified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
            out_hit   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_mask  <= match;
            out_hit   <= |match;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt <= '0;
        end else if (deliver && out_hit && (hit_cnt != CNT_MAX)) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_range_match_stream.sv
// Randomized and directed bench for range_match_stream against a queue-based
// reference model; a second instance with a 2-bit counter exercises saturation.
module tb_range_match_stream;

    localparam int W = 3;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] mask;
    } word_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_idx = '0;
    logic [W-1:0] cfg_lo = '0;
    logic [W-1:0] cfg_hi = '0;
    logic         cfg_en = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         cnt_clr = 1'b0;

    logic         in_ready, out_valid, out_hit;
    logic [W-1:0] out_data;
    logic [N-1:0] out_mask;
    logic [15:0]  hit_cnt;

    logic         s_in_ready, s_out_valid, s_out_hit;
    logic [W-1:0] s_out_data;
    logic [N-1:0] s_out_mask;
    logic [1:0]   s_hit_cnt;

    range_match_stream dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_en(cfg_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_hit(out_hit), .out_mask(out_mask),
        .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
    );

    range_match_stream #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_en(cfg_en),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_hit(s_out_hit), .out_mask(s_out_mask),
        .cnt_clr(cnt_clr), .hit_cnt(s_hit_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: range table, in-flight word queue, hit counters.
    logic [W-1:0] m_lo [N];
    logic [W-1:0] m_hi [N];
    logic         m_en [N];
    word_t        q[$];
    int           m_cnt16, m_cnt2;

    function automatic logic [N-1:0] classify(input logic [W-1:0] d);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++)
            m[i] = m_en[i] && (int'(m_lo[i]) <= int'(d)) && (int'(d) <= int'(m_hi[i]));
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lo[i] = (i == 0) ? 3'd4 : 3'd0;
            m_hi[i] = (i == 0) ? 3'd6 : 3'd0;
            m_en[i] = (i == 0);
        end
        q.delete();
        m_cnt16 = 0;
        m_cnt2  = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic exp_v;
        exp_v = (q.size() != 0);
        check({tag, ".out_valid"}, out_valid, exp_v);
        check({tag, ".sat_out_valid"}, s_out_valid, exp_v);
        if (exp_v) begin
            check({tag, ".out_data"}, out_data, q[0].data);
            check({tag, ".out_mask"}, out_mask, q[0].mask);
            check({tag, ".out_hit"}, out_hit, |q[0].mask);
            check({tag, ".sat_out_data"}, s_out_data, q[0].data);
            check({tag, ".sat_out_mask"}, s_out_mask, q[0].mask);
            check({tag, ".sat_out_hit"}, s_out_hit, |q[0].mask);
        end
        check({tag, ".hit_cnt"}, hit_cnt, m_cnt16);
        check({tag, ".sat_hit_cnt"}, s_hit_cnt, m_cnt2);
    endtask

    // One clock: drive inputs at the negedge (cfg_we/cnt_clr preset by caller),
    // predict the edge, then check outputs at the following negedge.
    task automatic cycle(input string tag, input logic iv, input logic [W-1:0] d, input logic ordy);
        logic  exp_rdy, done, hit_done, acc;
        word_t w;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = (q.size() == 0) || ordy;
        check({tag, ".in_ready"}, in_ready, exp_rdy);
        check({tag, ".sat_in_ready"}, s_in_ready, exp_rdy);
        done     = (q.size() != 0) && ordy;
        hit_done = done && (|q[0].mask);
        acc      = iv && exp_rdy;
        w.data   = d;
        w.mask   = classify(d);
        @(posedge clk);
        if (done) void'(q.pop_front());
        if (acc) q.push_back(w);
        if (cnt_clr) begin
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (hit_done) begin
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
            m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
        end
        if (cfg_we && int'(cfg_idx) < N) begin
            m_lo[cfg_idx] = cfg_lo;
            m_hi[cfg_idx] = cfg_hi;
            m_en[cfg_idx] = cfg_en;
        end
        @(negedge clk);
        cfg_we  = 1'b0;
        cnt_clr = 1'b0;
        check_outputs(tag);
    endtask

    task automatic set_cfg(input logic [1:0] idx, input logic [W-1:0] lo, input logic [W-1:0] hi, input logic en);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_lo  = lo;
        cfg_hi  = hi;
        cfg_en  = en;
    endtask

    initial begin
        model_reset();
        #1;
        check("reset.out_valid", out_valid, 0);
        check("reset.out_data", out_data, 0);
        check("reset.out_mask", out_mask, 0);
        check("reset.out_hit", out_hit, 0);
        check("reset.hit_cnt", hit_cnt, 0);
        check("reset.in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Default table, stream 0..7 at full rate.
        for (int i = 0; i < 8; i++) cycle("sweep", 1'b1, W'(i), 1'b1);
        cycle("sweep_drain", 1'b0, '0, 1'b1);
        check("sweep.hit_cnt_total", hit_cnt, 3);

        // Entry 1 = [0,1]; entry 2 = [5,3] is inverted and must never match.
        set_cfg(2'd1, 3'd0, 3'd1, 1'b1);
        cycle("cfg1", 1'b0, '0, 1'b1);
        set_cfg(2'd2, 3'd5, 3'd3, 1'b1);
        cycle("cfg2", 1'b0, '0, 1'b1);
        cycle("inv0", 1'b1, 3'd0, 1'b1);
        check("inv0.mask_const", out_mask, 4'b0010);
        cycle("inv5", 1'b1, 3'd5, 1'b1);
        check("inv5.mask_const", out_mask, 4'b0001);
        for (int i = 2; i < 8; i++) cycle("inv_sweep", 1'b1, W'(i), 1'b1);
        // lo == hi matches exactly one value.
        set_cfg(2'd3, 3'd7, 3'd7, 1'b1);
        cycle("cfg3", 1'b0, '0, 1'b1);
        cycle("eq6", 1'b1, 3'd6, 1'b1);
        cycle("eq7", 1'b1, 3'd7, 1'b1);
        check("eq7.mask_const", out_mask, 4'b1000);

        // Backpressure: word 6 held for 3 cycles, then released with no bubble.
        cycle("bp_load", 1'b1, 3'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold", 1'b1, 3'd2, 1'b0);
            check("bp_hold.data_const", out_data, 3'd6);
        end
        cycle("bp_release", 1'b1, 3'd2, 1'b1);
        check("bp_release.data_const", out_data, 3'd2);
        cycle("bp_drain", 1'b0, '0, 1'b1);

        // Saturation of the 2-bit counter, then clear coincident with a hit.
        cnt_clr = 1'b1;
        cycle("clr", 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) cycle("sat", 1'b1, 3'd5, 1'b1);
        cycle("sat_drain", 1'b0, '0, 1'b1);
        check("sat.sat_cnt_const", s_hit_cnt, 2'd3);
        cycle("clr_hit_load", 1'b1, 3'd5, 1'b1);
        cnt_clr = 1'b1;
        cycle("clr_hit", 1'b0, '0, 1'b1);
        check("clr_hit.cnt_const", hit_cnt, 0);

        // Disabling entry 0 on the accepting edge must not affect that word.
        set_cfg(2'd0, 3'd4, 3'd6, 1'b0);
        cycle("dis_same", 1'b1, 3'd5, 1'b1);
        check("dis_same.hit_const", out_hit, 1);
        cycle("dis_next", 1'b1, 3'd5, 1'b1);
        check("dis_next.hit_const", out_hit, 0);
        set_cfg(2'd0, 3'd4, 3'd6, 1'b1);
        cycle("restore", 1'b0, '0, 1'b1);

        // Random traffic, configuration and clears.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(7) == 0)
                set_cfg(2'($urandom_range(3)), W'($urandom_range(7)), W'($urandom_range(7)), 1'($urandom_range(1)));
            if ($urandom_range(31) == 0) cnt_clr = 1'b1;
            cycle("rand", 1'($urandom_range(3) != 0), W'($urandom_range(7)), 1'($urandom_range(3) != 0));
        end

        // Reset while a word is held: output drops at once, table back to defaults.
        set_cfg(2'd1, 3'd0, 3'd7, 1'b1);
        cycle("pre_rst_cfg", 1'b0, '0, 1'b1);
        cycle("pre_rst_load", 1'b1, 3'd3, 1'b0);
        cycle("pre_rst_hold", 1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst.out_valid", out_valid, 0);
        check("mid_rst.in_ready", in_ready, 1);
        check("mid_rst.hit_cnt", hit_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst5", 1'b1, 3'd5, 1'b1);
        check("post_rst5.mask_const", out_mask, 4'b0001);
        cycle("post_rst0", 1'b1, 3'd0, 1'b1);
        check("post_rst0.mask_const", out_mask, 4'b0000);
        cycle("post_rst_drain", 1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
